// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one data-memory port between the CPU MEM stage
// and a debug/loader master. CPU has default priority.
//
// Ports (clk_i, rst_i sync active-high):
//   cpu_*   : CPU request/we/addr/wdata in, rdata (comb) and stall out
//   dbg_*   : debug request/we/lock/addr/wdata in, gnt, rdata, rvalid out
//   mem_*   : memory strobes/addr/wdata out, comb rdata in
//   perf_*  : only with DM_ARB_PERF_EN defined; stall and debug-grant
//             event counters, wrap at 2^32, cleared by rst_i
//
// Fairness: a starvation counter forces a waiting debug request through
// after STARVE_MAX denied cycles; a burst counter hands the port back to
// a waiting CPU after BURST_MAX locked debug grants.
module dm_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic              dbg_lock_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_rvalid_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_cpu_stall_o,
  output logic [31:0]       perf_dbg_gnt_o
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);
  localparam logic [BW-1:0] B_MAX = BW'(BURST_MAX);
  localparam logic [BW-1:0] B_ONE = BW'(1);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } own_e;

  own_e          state_q;
  own_e          state_d;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic [BW-1:0] burst_q;
  logic [BW-1:0] burst_d;

  logic dbg_gnt;
  logic cpu_gnt;
  logic dbg_rd;

  // Grant decision. Reset masks both grants so no strobe can fire.
  always_comb begin
    dbg_gnt = 1'b0;
    if (!rst_i && dbg_req_i) begin
      unique case (state_q)
        OWN_CPU: dbg_gnt = !cpu_req_i || (starve_q == S_MAX);
        OWN_DBG: dbg_gnt = !cpu_req_i || (burst_q < B_MAX);
      endcase
    end
    cpu_gnt = !rst_i && cpu_req_i && !dbg_gnt;
  end

  assign dbg_rd = dbg_gnt && !dbg_we_i;

  assign dbg_gnt_o   = dbg_gnt;
  assign cpu_stall_o = !rst_i && cpu_req_i && !cpu_gnt;
  assign cpu_rdata_o = mem_rdata_i;

  // Memory port mux: idle cycles drive zeros.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      dbg_gnt: begin
        mem_we_o    = dbg_we_i;
        mem_re_o    = !dbg_we_i;
        mem_addr_o  = dbg_addr_i;
        mem_wdata_o = dbg_wdata_i;
      end
      cpu_gnt: begin
        mem_we_o    = cpu_we_i;
        mem_re_o    = !cpu_we_i;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
      end
      default: ;
    endcase
  end

  // Next state. Any cycle without a locked debug grant ends the burst.
  always_comb begin
    state_d  = OWN_CPU;
    burst_d  = '0;
    starve_d = '0;
    if (dbg_req_i && !dbg_gnt) begin
      if (starve_q == S_MAX) begin
        starve_d = S_MAX;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
    if (dbg_gnt && dbg_lock_i) begin
      state_d = OWN_DBG;
      if (state_q == OWN_CPU) begin
        burst_d = B_ONE;
      end else if (burst_q == B_MAX) begin
        burst_d = B_MAX;
      end else begin
        burst_d = burst_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= OWN_CPU;
      starve_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
    end
  end

  // Debug read data is captured at the edge that ends the granted read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dbg_rvalid_o <= 1'b0;
      dbg_rdata_o  <= '0;
    end else begin
      dbg_rvalid_o <= dbg_rd;
      if (dbg_rd) begin
        dbg_rdata_o <= mem_rdata_i;
      end
    end
  end

`ifdef DM_ARB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_cpu_stall_o <= '0;
      perf_dbg_gnt_o   <= '0;
    end else begin
      if (cpu_stall_o) begin
        perf_cpu_stall_o <= perf_cpu_stall_o + 32'd1;
      end
      if (dbg_gnt) begin
        perf_dbg_gnt_o <= perf_dbg_gnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
